// File: rtl/mac_dot_product.sv
// mac_dot_product
//   Pipelined unsigned multiply-accumulate engine. It accepts LENGTH operand
//   pairs over a valid/ready stream and sums their products. The dot product
//   is then presented on a valid/ready output. After the result handshake the
//   block clears itself and starts the next vector.
//
//   Optional feature macro: MAC_SATURATE_EN
//     defined   : accumulator clamps to all-ones on overflow
//     undefined : accumulator wraps modulo 2^ACC_WIDTH
//   In both builds the sticky overflow flag is set.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous abort of the current vector
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair
//   a, b       operands (WIDTH bits, unsigned)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     dot product (ACC_WIDTH bits)
//   overflow   sticky accumulator overflow for the current vector
//
// States
//   ACC | accepting and accumulating terms
//   OUT | holding result until out_ready
module mac_dot_product #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LENGTH    = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_WIDTH-1:0] LEN  = CNT_WIDTH'(LENGTH);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LENGTH - 1);

  typedef enum logic {ACC, OUT} state_t;

  state_t               state;
  state_t               state_next;
  logic [PW-1:0]        prod;
  logic                 p_valid;
  logic [CNT_WIDTH-1:0] cnt_in;
  logic [CNT_WIDTH-1:0] cnt_acc;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 last_term;
  logic                 handshake;
  logic                 accept;

  // One extra bit on the add exposes the carry used for overflow detection.
  always_comb begin
    sum   = {1'b0, acc} + {{(ACC_WIDTH + 1 - PW){1'b0}}, prod};
    carry = sum[ACC_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    handshake  = 1'b0;
    last_term  = p_valid && (cnt_acc == LAST);
    case (state)
      ACC: begin
        in_ready = (cnt_in < LEN);
        if (last_term) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        handshake = out_ready;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
    if (clear) begin
      state_next = ACC;
      handshake  = 1'b0;
    end
  end

  assign accept = in_valid & in_ready;
  assign result = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod     <= '0;
      p_valid  <= 1'b0;
      cnt_in   <= '0;
      cnt_acc  <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      prod     <= '0;
      p_valid  <= 1'b0;
      cnt_in   <= '0;
      cnt_acc  <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        prod   <= PW'(a) * PW'(b);
        cnt_in <= cnt_in + CNT_WIDTH'(1);
      end
      if (p_valid) begin
        cnt_acc <= cnt_acc + CNT_WIDTH'(1);
        if (carry) begin
          overflow <= 1'b1;
`ifdef MAC_SATURATE_EN
          // Once clamped, any further nonzero add carries again, so the
          // accumulator stays pinned at all-ones for the rest of the vector.
          acc <= '1;
`else
          acc <= sum[ACC_WIDTH-1:0];
`endif
        end else begin
          acc <= sum[ACC_WIDTH-1:0];
        end
      end
      // Result consumed: restart for the next vector.
      if (handshake) begin
        acc      <= '0;
        cnt_in   <= '0;
        cnt_acc  <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_product.sv
module tb_mac_dot_product;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]      clear_v     = '0;
  logic [2:0]      in_valid_v  = '0;
  logic [2:0]      out_ready_v = '0;
  logic [2:0][7:0] a_v         = '0;
  logic [2:0][7:0] b_v         = '0;
  logic [2:0]      in_ready_v;
  logic [2:0]      out_valid_v;
  logic [2:0]      overflow_v;
  logic [23:0]     res0;
  logic [15:0]     res1;
  logic [23:0]     res2;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  // u0: default build, u1: narrow accumulator, u2: single-term vectors
  mac_dot_product u0 (
    .clk(clk), .rst(rst), .clear(clear_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .result(res0), .overflow(overflow_v[0]));

  mac_dot_product #(.WIDTH(8), .ACC_WIDTH(16), .LENGTH(2), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .clear(clear_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .result(res1), .overflow(overflow_v[1]));

  mac_dot_product #(.WIDTH(8), .ACC_WIDTH(24), .LENGTH(1), .CNT_WIDTH(8)) u2 (
    .clk(clk), .rst(rst), .clear(clear_v[2]), .in_valid(in_valid_v[2]),
    .in_ready(in_ready_v[2]), .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .result(res2), .overflow(overflow_v[2]));

  function automatic logic [31:0] get_res(input int s);
    case (s)
      0:       get_res = {8'd0, res0};
      1:       get_res = {16'd0, res1};
      default: get_res = {8'd0, res2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one pair and returns at the negedge after the accepting edge;
  // in_valid is left high so callers can stream back-to-back.
  task automatic send(input int s, input logic [7:0] av, input logic [7:0] bv);
    logic ok;
    a_v[s] = av;
    b_v[s] = bv;
    in_valid_v[s] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = in_ready_v[s];
      @(negedge clk);
    end
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_out(input int s, input logic [31:0] exp_res, input logic exp_ovf,
                          input int stall, input string tag);
    logic ok;
    in_valid_v[s] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid_v[s]) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_out_valid"}, {31'd0, ok}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_result"}, get_res(s), exp_res);
      @(negedge clk);
    end
    chk({tag, "_result"}, get_res(s), exp_res);
    chk({tag, "_overflow"}, {31'd0, overflow_v[s]}, {31'd0, exp_ovf});
    out_ready_v[s] = 1'b1;
    @(negedge clk);
    out_ready_v[s] = 1'b0;
    chk({tag, "_post_valid"}, {31'd0, out_valid_v[s]}, 32'd0);
    chk({tag, "_post_ready"}, {31'd0, in_ready_v[s]}, 32'd1);
    chk({tag, "_post_result"}, get_res(s), 32'd0);
    chk({tag, "_post_ovf"}, {31'd0, overflow_v[s]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] corner [7];
    logic [7:0] ta, tb;
    logic [31:0] exp_sat;
    corner = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};

    // Reset values while rst is held
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    chk("rst_result", get_res(0), 32'd0);
    chk("rst_overflow", {31'd0, overflow_v[0]}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: back-to-back vector, latency check
    send(0, 8'd1, 8'd5);
    send(0, 8'd2, 8'd6);
    send(0, 8'd3, 8'd7);
    send(0, 8'd4, 8'd8);
    in_valid_v[0] = 1'b0;
    chk("lat_not_yet", {31'd0, out_valid_v[0]}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid_v[0]}, 32'd1);
    chk("t1_result", get_res(0), 32'd70);
    chk("t1_overflow", {31'd0, overflow_v[0]}, 32'd0);

    // 2: hold result under backpressure while a term is offered
    a_v[0] = 8'd1;
    b_v[0] = 8'd1;
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_result", get_res(0), 32'd70);
      chk("t2_hold_ready", {31'd0, in_ready_v[0]}, 32'd0);
      chk("t2_hold_valid", {31'd0, out_valid_v[0]}, 32'd1);
      @(negedge clk);
    end
    wait_out(0, 32'd70, 1'b0, 0, "t2a");
    for (int i = 0; i < 4; i++) send(0, 8'd255, 8'd255);
    wait_out(0, 32'd260100, 1'b0, 2, "t2b");

    // 3: narrow accumulator overflow
`ifdef MAC_SATURATE_EN
    exp_sat = 32'd65535;
`else
    exp_sat = 32'd64514;
`endif
    send(1, 8'd255, 8'd255);
    send(1, 8'd255, 8'd255);
    wait_out(1, exp_sat, 1'b1, 1, "t3_ovf");
    send(1, 8'd10, 8'd10);
    send(1, 8'd20, 8'd20);
    wait_out(1, 32'd500, 1'b0, 0, "t3_after");

    // 4: clear mid-vector, with a term offered in the same cycle
    send(0, 8'd9, 8'd9);
    send(0, 8'd9, 8'd9);
    clear_v[0] = 1'b1;
    a_v[0] = 8'd50;
    b_v[0] = 8'd50;
    @(negedge clk);
    clear_v[0] = 1'b0;
    in_valid_v[0] = 1'b0;
    chk("t4_clr_result", get_res(0), 32'd0);
    chk("t4_clr_ready", {31'd0, in_ready_v[0]}, 32'd1);
    @(negedge clk);
    chk("t4_clr_drained", get_res(0), 32'd0);
    for (int i = 0; i < 4; i++) send(0, 8'd1, 8'd1);
    wait_out(0, 32'd4, 1'b0, 0, "t4");

    // 5: asynchronous reset while a result is held
    for (int i = 0; i < 4; i++) send(0, 8'd2, 8'd3);
    in_valid_v[0] = 1'b0;
    for (int i = 0; i < 10 && !out_valid_v[0]; i++) @(negedge clk);
    chk("t5_pre_valid", {31'd0, out_valid_v[0]}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid_v[0]}, 32'd0);
    chk("t5_rst_result", get_res(0), 32'd0);
    chk("t5_rst_overflow", {31'd0, overflow_v[0]}, 32'd0);
    chk("t5_rst_ready", {31'd0, in_ready_v[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 8'd2, 8'd3);
    send(0, 8'd200, 8'd100);
    send(0, 8'd0, 8'd77);
    send(0, 8'd15, 8'd16);
    wait_out(0, 32'd20246, 1'b0, 0, "t5");

    // 6: single-term vectors with bubbles and stalls
    for (int i = 0; i < 49 + 150; i++) begin
      if (i < 49) begin
        ta = corner[i / 7];
        tb = corner[i % 7];
      end else begin
        ta = 8'($urandom_range(0, 255));
        tb = 8'($urandom_range(0, 255));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(2, ta, tb);
      wait_out(2, 32'(ta) * 32'(tb), 1'b0, $urandom_range(0, 2), "t6");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
